// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode seven-segment
// display. It shows a 16-bit value as 4 hex digits. Each digit owns a slot of
// REFRESH_DIV cycles. The first BLANK_CYCLES of every slot are dark, which
// stops the previous digit ghosting onto the next one.
//
// The inputs are captured into shadow registers once per frame, at the end of
// digit 3's slot, so all 4 digits of a frame come from one sample. Reset also
// captures them.
//
// Ports:
//   clk    in   1   system clock
//   rst    in   1   synchronous reset, active-high
//   value  in  16   hex value; digit 0 = value[3:0] (rightmost)
//   dp     in   4   decimal point request per digit, active-high
//   lz_en  in   1   1 = suppress leading zeros
//   an     out  4   digit enables, active-low; an[0] = rightmost digit
//   cat    out  8   segments, active-low; cat[0]=a .. cat[6]=g, cat[7]=dp
module seg7_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [7:0]  cat
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      val_s_q, val_s_d;
    logic [3:0]       dp_s_q, dp_s_d;
    logic             lz_s_q, lz_s_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       cat_q, cat_d;

    logic             slot_end;
    logic             in_blank;
    logic             lead_zero;
    logic [3:0]       nibble;
    logic [7:0]       seg;

    // Segment patterns with the decimal point off (cat[7]=1), active-low.
    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // With no blank phase the compare against zero would be constant, so it
    // is left out.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
        assign in_blank = (cnt_q < BLANK_C);
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        val_s_d = val_s_q;
        dp_s_d  = dp_s_q;
        lz_s_d  = lz_s_q;

        slot_end = (cnt_q == CNT_LAST);
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
            // Frame boundary: take a new coherent sample of the inputs.
            if (idx_q == 2'd3) begin
                val_s_d = value;
                dp_s_d  = dp;
                lz_s_d  = lz_en;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        nibble = val_s_q[{idx_q, 2'b00} +: 4];

        // A digit is a leading zero when it and every digit to its left are 0.
        // Digit 0 is never treated as one, so a value of 0 still shows "0".
        case (idx_q)
            2'd1:    lead_zero = (val_s_q[15:4] == 12'h000);
            2'd2:    lead_zero = (val_s_q[15:8] == 8'h00);
            2'd3:    lead_zero = (val_s_q[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase

        seg = seg_decode(nibble);

        an_d  = 4'hF;
        cat_d = 8'hFF;
        if (!in_blank) begin
            an_d           = ~(4'b0001 << idx_q);
            cat_d[6:0]     = (lz_s_q && lead_zero) ? 7'h7F : seg[6:0];
            cat_d[7]       = ~dp_s_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            val_s_q <= value;
            dp_s_q  <= dp;
            lz_s_q  <= lz_en;
            an_q    <= 4'hF;
            cat_q   <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            val_s_q <= val_s_d;
            dp_s_q  <= dp_s_d;
            lz_s_q  <= lz_s_d;
            an_q    <= an_d;
            cat_q   <= cat_d;
        end
    end

    assign an  = an_q;
    assign cat = cat_q;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  an;
  logic [7:0]  cat;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .lz_en(lz_en),
    .an(an), .cat(cat)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Hex decode table, active-low, decimal point off.
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: position in the frame counted in plain cycles since reset;
  // slot and digit follow by division, the shown digit by shifting the sample.
  int unsigned m_pos = 0;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic        m_valid = 1'b0;
  logic        exp_blank = 1'b1;
  logic [3:0]  exp_an = 4'hF;
  logic [7:0]  exp_cat = 8'hFF;
  int          m_dig;
  logic [15:0] m_sh;

  always @(posedge clk) begin
    if (rst) begin
      exp_blank = 1'b1; exp_an = 4'hF; exp_cat = 8'hFF;
      m_val = value; m_dp = dp; m_lz = lz_en;
      m_pos = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_dig = int'(m_pos / RD) % 4;
      m_sh  = m_val >> (4 * m_dig);
      if (int'(m_pos % RD) < BC) begin
        exp_blank = 1'b1; exp_an = 4'hF; exp_cat = 8'hFF;
      end else begin
        exp_blank = 1'b0;
        exp_an = 4'hF;
        exp_an[m_dig] = 1'b0;
        exp_cat = seg_tab[m_sh[3:0]];
        if (m_lz && m_dig > 0 && m_sh == 16'h0) exp_cat = 8'hFF;
        exp_cat[7] = ~m_dp[m_dig];
      end
      if (m_pos == 4 * RD - 1) begin
        m_val = value; m_dp = dp; m_lz = lz_en;
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  end

  task automatic check(input string name, input logic [3:0] got_an, input logic [7:0] got_cat,
                       input logic [3:0] want_an, input logic [7:0] want_cat);
    n_tests++;
    if (got_an !== want_an || got_cat !== want_cat) begin
      n_fail++;
      $display("FAIL %s: got an=%h cat=%h, expected an=%h cat=%h", name, got_an, got_cat,
               want_an, want_cat);
    end
  endtask

  // Scoreboard against the model on every cycle, plus the one-digit-lit rule.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model", an, cat, exp_an, exp_cat);
      n_tests++;
      if (exp_blank ? (an !== 4'hF) : ($countones(~an) != 1)) begin
        n_fail++;
        $display("FAIL an_onehot: got an=%h, expected blank=%0b", an, exp_blank);
      end
    end
  end

  // driver tasks
  int cur_e = 0;

  task automatic do_reset(input logic [15:0] v, input logic [3:0] d, input logic l);
    @(negedge clk);
    rst = 1'b1; value = v; dp = d; lz_en = l;
    @(negedge clk);
    rst = 1'b0;
    cur_e = 0;
  endtask

  task automatic goto_edge(input int e);
    while (cur_e < e) begin
      @(negedge clk);
      cur_e++;
    end
  endtask

  typedef struct { int e; logic [3:0] an; logic [7:0] cat; } edge_chk_t;
  edge_chk_t etab[$];

  task automatic run_etab(input string name);
    for (int i = 0; i < etab.size(); i++) begin
      goto_edge(etab[i].e);
      check(name, an, cat, etab[i].an, etab[i].cat);
    end
    etab.delete();
  endtask

  typedef struct {
    logic [15:0] v; logic [3:0] d; logic l; int dig; logic [3:0] an; logic [7:0] cat;
  } dig_vec_t;
  dig_vec_t dtab[$];

  logic [15:0] sweep [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
  logic [15:0] sw;

  initial begin
    // Reset held for 3 edges, then scan from digit 0 with 0x1234.
    repeat (3) @(negedge clk);
    check("reset_hold", an, cat, 4'hF, 8'hFF);
    rst = 1'b0;
    cur_e = 0;
    etab.push_back('{1, 4'hF, 8'hFF});
    etab.push_back('{2, 4'hF, 8'hFF});
    etab.push_back('{3, 4'hE, 8'h99});
    etab.push_back('{8, 4'hE, 8'h99});
    etab.push_back('{9, 4'hF, 8'hFF});
    etab.push_back('{10, 4'hF, 8'hFF});
    etab.push_back('{11, 4'hD, 8'hB0});
    etab.push_back('{16, 4'hD, 8'hB0});
    etab.push_back('{19, 4'hB, 8'hA4});
    etab.push_back('{27, 4'h7, 8'hF9});
    run_etab("reset_release");

    // Frame coherence: change mid-frame, shown only from the next frame.
    do_reset(16'h1234, 4'h0, 1'b0);
    goto_edge(10);
    value = 16'hABCD;
    etab.push_back('{13, 4'hD, 8'hB0});
    etab.push_back('{19, 4'hB, 8'hA4});
    etab.push_back('{27, 4'h7, 8'hF9});
    etab.push_back('{35, 4'hE, 8'hA1});
    etab.push_back('{43, 4'hD, 8'hC6});
    etab.push_back('{51, 4'hB, 8'h83});
    etab.push_back('{59, 4'h7, 8'h88});
    run_etab("frame_coherence");

    // Per-digit vectors: leading zeros and decimal points.
    dtab.push_back('{16'h0005, 4'h0, 1'b1, 3, 4'h7, 8'hFF});
    dtab.push_back('{16'h0005, 4'h0, 1'b1, 1, 4'hD, 8'hFF});
    dtab.push_back('{16'h0005, 4'h0, 1'b1, 0, 4'hE, 8'h92});
    dtab.push_back('{16'h0000, 4'h0, 1'b1, 0, 4'hE, 8'hC0});
    dtab.push_back('{16'h0000, 4'h0, 1'b1, 2, 4'hB, 8'hFF});
    dtab.push_back('{16'h0105, 4'h0, 1'b1, 3, 4'h7, 8'hFF});
    dtab.push_back('{16'h0105, 4'h0, 1'b1, 2, 4'hB, 8'hF9});
    dtab.push_back('{16'h0105, 4'h0, 1'b1, 1, 4'hD, 8'hC0});
    dtab.push_back('{16'h0005, 4'h0, 1'b0, 3, 4'h7, 8'hC0});
    dtab.push_back('{16'h8888, 4'h4, 1'b0, 2, 4'hB, 8'h00});
    dtab.push_back('{16'h8888, 4'h4, 1'b0, 0, 4'hE, 8'h80});
    dtab.push_back('{16'h8888, 4'h4, 1'b0, 1, 4'hD, 8'h80});
    dtab.push_back('{16'h8888, 4'h4, 1'b0, 3, 4'h7, 8'h80});
    dtab.push_back('{16'h0000, 4'h8, 1'b1, 3, 4'h7, 8'h7F});
    for (int i = 0; i < dtab.size(); i++) begin
      do_reset(dtab[i].v, dtab[i].d, dtab[i].l);
      goto_edge(RD * dtab[i].dig + BC + 1);
      check("digit_vec", an, cat, dtab[i].an, dtab[i].cat);
    end

    // Reset during digit 2's drive phase.
    do_reset(16'h1234, 4'h0, 1'b0);
    goto_edge(20);
    rst = 1'b1; value = 16'h5A5A; dp = 4'h0; lz_en = 1'b0;
    @(negedge clk);
    check("midscan_reset", an, cat, 4'hF, 8'hFF);
    rst = 1'b0;
    cur_e = 0;
    etab.push_back('{1, 4'hF, 8'hFF});
    etab.push_back('{3, 4'hE, 8'h88});
    etab.push_back('{11, 4'hD, 8'h92});
    run_etab("midscan_restart");

    // Full sweep of all 16 codes, one frame per value.
    do_reset(sweep[0], 4'h0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      sw = sweep[f];
      for (int d = 0; d < 4; d++) begin
        goto_edge(4 * RD * f + RD * d + BC + 1);
        check("sweep", an, cat, ~(4'b0001 << d), seg_tab[sw[4*d +: 4]]);
        if (d == 0 && f < 3) value = sweep[f + 1];
      end
    end

    // Random traffic, scored by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 2))
          0: value = 16'($urandom_range(0, 65535));
          1: value = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
          default: value = 16'h0000;
        endcase
        dp = 4'($urandom_range(0, 15));
        lz_en = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
